// File: rtl/vga_timing.sv
// ---------------------------------------------------------------------------
// vga_timing
//
// Purpose:
//   Raster timing generator for the paddle game (640x480@60 by default).
//   A clock divider produces a pixel tick; horizontal and vertical counters
//   walk the full raster, and every output is a registered decode of the
//   counters, refreshed on the pixel tick.
//
// Ports:
//   clck      - system clock
//   reset_n   - synchronous active-low reset
//   hsync     - horizontal sync, active low
//   vsync     - vertical sync, active low
//   visible   - current pixel lies inside the active area
//   vgax      - current pixel column (0 when the column is outside the active width)
//   vgay      - current pixel row (0 when the row is outside the active height)
//   update    - one-clck strobe when the raster enters vertical blanking
//   pix_tick  - one-clck strobe marking that the outputs just advanced a pixel
// ---------------------------------------------------------------------------
module vga_timing #(
    parameter int CLK_DIV   = 2,
    parameter int H_VISIBLE = 640,
    parameter int H_FRONT   = 16,
    parameter int H_SYNC    = 96,
    parameter int H_BACK    = 48,
    parameter int V_VISIBLE = 480,
    parameter int V_FRONT   = 10,
    parameter int V_SYNC    = 2,
    parameter int V_BACK    = 33
) (
    input  logic       clck,
    input  logic       reset_n,
    output logic       hsync,
    output logic       vsync,
    output logic       visible,
    output logic [9:0] vgax,
    output logic [8:0] vgay,
    output logic       update,
    output logic       pix_tick
);

    localparam int HT = H_VISIBLE + H_FRONT + H_SYNC + H_BACK;
    localparam int VT = V_VISIBLE + V_FRONT + V_SYNC + V_BACK;
    localparam int HW = $clog2(HT);
    localparam int VW = $clog2(VT);
    localparam int DW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

    localparam logic [DW-1:0] DIV_LAST     = DW'(CLK_DIV - 1);
    localparam logic [HW-1:0] H_LAST       = HW'(HT - 1);
    localparam logic [HW-1:0] H_VIS_END    = HW'(H_VISIBLE);
    localparam logic [HW-1:0] H_SYNC_FIRST = HW'(H_VISIBLE + H_FRONT);
    localparam logic [HW-1:0] H_SYNC_LAST  = HW'(H_VISIBLE + H_FRONT + H_SYNC - 1);
    localparam logic [VW-1:0] V_LAST       = VW'(VT - 1);
    localparam logic [VW-1:0] V_VIS_END    = VW'(V_VISIBLE);
    localparam logic [VW-1:0] V_SYNC_FIRST = VW'(V_VISIBLE + V_FRONT);
    localparam logic [VW-1:0] V_SYNC_LAST  = VW'(V_VISIBLE + V_FRONT + V_SYNC - 1);

    logic [DW-1:0] divCount_q, divCount_d;
    logic          tick;
    logic [HW-1:0] hCount_q, hCount_d;
    logic [VW-1:0] vCount_q, vCount_d;
    logic          hInVis, vInVis;

    logic          hsync_q, hsync_d;
    logic          vsync_q, vsync_d;
    logic          visible_q, visible_d;
    logic [9:0]    vgax_q, vgax_d;
    logic [8:0]    vgay_q, vgay_d;
    logic          update_q, update_d;
    logic          pixTick_q, pixTick_d;

    // Pixel divider: the tick marks the last clck of each pixel period.
    // With CLK_DIV=1 the counter is pinned at zero and the tick is constant.
    always_comb begin
        tick       = (divCount_q == DIV_LAST);
        divCount_d = tick ? '0 : divCount_q + 1'b1;
    end

    // Raster counters: h steps once per tick and wraps at the end of the
    // line, carrying into v, which wraps at the end of the frame.
    always_comb begin
        hCount_d = hCount_q;
        vCount_d = vCount_q;
        if (tick) begin
            if (hCount_q == H_LAST) begin
                hCount_d = '0;
                vCount_d = (vCount_q == V_LAST) ? '0 : vCount_q + 1'b1;
            end else begin
                hCount_d = hCount_q + 1'b1;
            end
        end
    end

    // Output decode: the outputs capture the decode of the counter values
    // on the same tick that moves the counters on, so they show the pixel
    // the counters held one clck earlier and change only together with
    // pix_tick. update is a single-clck pulse on the tick that presents
    // the first blanking line's first pixel.
    always_comb begin
        hInVis    = (hCount_q < H_VIS_END);
        vInVis    = (vCount_q < V_VIS_END);
        hsync_d   = hsync_q;
        vsync_d   = vsync_q;
        visible_d = visible_q;
        vgax_d    = vgax_q;
        vgay_d    = vgay_q;
        update_d  = 1'b0;
        pixTick_d = tick;
        if (tick) begin
            visible_d = hInVis && vInVis;
            vgax_d    = hInVis ? 10'(hCount_q) : 10'd0;
            vgay_d    = vInVis ? 9'(vCount_q) : 9'd0;
            hsync_d   = !((hCount_q >= H_SYNC_FIRST) && (hCount_q <= H_SYNC_LAST));
            vsync_d   = !((vCount_q >= V_SYNC_FIRST) && (vCount_q <= V_SYNC_LAST));
            update_d  = (hCount_q == '0) && (vCount_q == V_VIS_END);
        end
    end

    // State registers. Reset restarts the raster at (0,0) with sync
    // deasserted, so a mid-frame reset never leaves a partial pulse.
    always_ff @(posedge clck) begin
        if (!reset_n) begin
            divCount_q <= '0;
            hCount_q   <= '0;
            vCount_q   <= '0;
            hsync_q    <= 1'b1;
            vsync_q    <= 1'b1;
            visible_q  <= 1'b0;
            vgax_q     <= '0;
            vgay_q     <= '0;
            update_q   <= 1'b0;
            pixTick_q  <= 1'b0;
        end else begin
            divCount_q <= divCount_d;
            hCount_q   <= hCount_d;
            vCount_q   <= vCount_d;
            hsync_q    <= hsync_d;
            vsync_q    <= vsync_d;
            visible_q  <= visible_d;
            vgax_q     <= vgax_d;
            vgay_q     <= vgay_d;
            update_q   <= update_d;
            pixTick_q  <= pixTick_d;
        end
    end

    assign hsync    = hsync_q;
    assign vsync    = vsync_q;
    assign visible  = visible_q;
    assign vgax     = vgax_q;
    assign vgay     = vgay_q;
    assign update   = update_q;
    assign pix_tick = pixTick_q;

endmodule

// File: tb/tb_vga_timing.sv
// ---------------------------------------------------------------------------
// tb_vga_timing
//
// Scoreboard bench for vga_timing using a shrunken raster (15x10 pixels per
// frame) so whole frames fit in a short run. Instance A divides by two,
// instance B runs one pixel per clck. Stimulus pushes expected pixels into
// per-instance queues; monitors pop one entry per pix_tick and compare.
// ---------------------------------------------------------------------------
module tb_vga_timing;

    localparam int HV = 8;
    localparam int HF = 2;
    localparam int HS = 3;
    localparam int HB = 2;
    localparam int VV = 6;
    localparam int VF = 1;
    localparam int VS = 2;
    localparam int VB = 1;
    localparam int HT = HV + HF + HS + HB;
    localparam int VT = VV + VF + VS + VB;
    localparam int FRAME = HT * VT;

    typedef struct packed {
        int         pix;
        logic [9:0] x;
        logic [8:0] y;
        logic       vis;
        logic       hs;
        logic       vs;
        logic       upd;
    } pixel_t;

    logic       clk = 1'b0;
    logic       rstA_n = 1'b0;
    logic       rstB_n = 1'b0;
    logic       hsyncA, vsyncA, visibleA, updateA, pixTickA;
    logic [9:0] vgaxA;
    logic [8:0] vgayA;
    logic       hsyncB, vsyncB, visibleB, updateB, pixTickB;
    logic [9:0] vgaxB;
    logic [8:0] vgayB;

    pixel_t qA[$];
    pixel_t qB[$];
    int     checks = 0;
    int     errors = 0;
    int     sinceA = 0;
    int     sinceB = 0;
    bit     gapValidA = 1'b0;
    bit     gapValidB = 1'b0;
    pixel_t lastA;

    always #5 clk = ~clk;

    vga_timing #(
        .CLK_DIV(2), .H_VISIBLE(HV), .H_FRONT(HF), .H_SYNC(HS), .H_BACK(HB),
        .V_VISIBLE(VV), .V_FRONT(VF), .V_SYNC(VS), .V_BACK(VB)
    ) dutA (
        .clck(clk), .reset_n(rstA_n), .hsync(hsyncA), .vsync(vsyncA),
        .visible(visibleA), .vgax(vgaxA), .vgay(vgayA), .update(updateA),
        .pix_tick(pixTickA)
    );

    vga_timing #(
        .CLK_DIV(1), .H_VISIBLE(HV), .H_FRONT(HF), .H_SYNC(HS), .H_BACK(HB),
        .V_VISIBLE(VV), .V_FRONT(VF), .V_SYNC(VS), .V_BACK(VB)
    ) dutB (
        .clck(clk), .reset_n(rstB_n), .hsync(hsyncB), .vsync(vsyncB),
        .visible(visibleB), .vgax(vgaxB), .vgay(vgayB), .update(updateB),
        .pix_tick(pixTickB)
    );

    // Builds a pixel record; f packs {visible, hsync, vsync, update}.
    function automatic pixel_t mk(input int x, input int y, input bit [3:0] f);
        pixel_t p;
        p.pix = 0;
        p.x   = 10'(x);
        p.y   = 9'(y);
        p.vis = f[3];
        p.hs  = f[2];
        p.vs  = f[1];
        p.upd = f[0];
        return p;
    endfunction

    // Expected outputs for the idx-th pixel after the raster starts at (0,0).
    function automatic pixel_t expectPixel(input int idx);
        int     h;
        int     v;
        bit     vis, hs, vs, upd;
        pixel_t p;
        h   = idx % HT;
        v   = (idx / HT) % VT;
        vis = (h < HV) && (v < VV);
        hs  = !((h >= HV + HF) && (h < HV + HF + HS));
        vs  = !((v >= VV + VF) && (v < VV + VF + VS));
        upd = (h == 0) && (v == VV);
        p     = mk((h < HV) ? h : 0, (v < VV) ? v : 0, {vis, hs, vs, upd});
        p.pix = v * HT + h;
        return p;
    endfunction

    // Hand-computed raster landmarks (frame-relative pixel number v*15+h).
    function automatic bit directedPixel(input int pix, output pixel_t p);
        bit found;
        found = 1'b1;
        p     = mk(0, 0, 4'b0110);
        case (pix)
            0:       p = mk(0, 0, 4'b1110);
            7:       p = mk(7, 0, 4'b1110);
            8:       p = mk(0, 0, 4'b0110);
            10:      p = mk(0, 0, 4'b0010);
            12:      p = mk(0, 0, 4'b0010);
            13:      p = mk(0, 0, 4'b0110);
            82:      p = mk(7, 5, 4'b1110);
            83:      p = mk(0, 5, 4'b0110);
            90:      p = mk(0, 0, 4'b0111);
            105:     p = mk(0, 0, 4'b0100);
            134:     p = mk(0, 0, 4'b0100);
            135:     p = mk(0, 0, 4'b0110);
            145:     p = mk(0, 0, 4'b0010);
            default: found = 1'b0;
        endcase
        p.pix = pix;
        return found;
    endfunction

    function automatic pixel_t sample(input int which);
        pixel_t p;
        if (which == 0) begin
            p = mk(int'(vgaxA), int'(vgayA), {visibleA, hsyncA, vsyncA, updateA});
        end else begin
            p = mk(int'(vgaxB), int'(vgayB), {visibleB, hsyncB, vsyncB, updateB});
        end
        return p;
    endfunction

    task automatic checkOutput(input string name, input int got, input int exp);
        checks++;
        if (got != exp) begin
            errors++;
            $display("[TB] FAIL %s: got %0d, expected %0d", name, got, exp);
        end
    endtask

    task automatic comparePixel(input string name, input pixel_t got, input pixel_t exp);
        checks++;
        if (got.x !== exp.x || got.y !== exp.y || got.vis !== exp.vis ||
            got.hs !== exp.hs || got.vs !== exp.vs || got.upd !== exp.upd) begin
            errors++;
            $display("[TB] FAIL %s pix %0d: got x=%0d y=%0d vis=%b hs=%b vs=%b upd=%b, expected x=%0d y=%0d vis=%b hs=%b vs=%b upd=%b",
                     name, exp.pix, got.x, got.y, got.vis, got.hs, got.vs, got.upd,
                     exp.x, exp.y, exp.vis, exp.hs, exp.vs, exp.upd);
        end
    endtask

    task automatic applyStimulus(input int which, input int count);
        for (int i = 0; i < count; i++) begin
            if (which == 0) qA.push_back(expectPixel(i));
            else            qB.push_back(expectPixel(i));
        end
    endtask

    task automatic checkReset(input int which);
        comparePixel(which == 0 ? "resetA" : "resetB", sample(which), mk(0, 0, 4'b0110));
        checkOutput(which == 0 ? "resetTickA" : "resetTickB",
                    int'(which == 0 ? pixTickA : pixTickB), 0);
    endtask

    // Counts rising edges from reset release until pix_tick is seen.
    task automatic waitFirstTick(input int which, input int expected);
        int n;
        bit seen;
        n    = 0;
        seen = 1'b0;
        while (!seen && n < 10) begin
            @(posedge clk);
            n++;
            #1;
            seen = (which == 0) ? (pixTickA === 1'b1) : (pixTickB === 1'b1);
        end
        checkOutput(which == 0 ? "firstTickA" : "firstTickB", n, expected);
    endtask

    task automatic drain(input int which, input int limit);
        int n;
        n = 0;
        while (((which == 0) ? qA.size() : qB.size()) != 0 && n < limit) begin
            @(posedge clk);
            n++;
        end
        checkOutput(which == 0 ? "drainA" : "drainB",
                    (which == 0) ? qA.size() : qB.size(), 0);
    endtask

    // Monitor A: scoreboard pop on each pix_tick, tick spacing, and
    // outputs holding (with update low) between ticks.
    always @(negedge clk) begin
        pixel_t got;
        pixel_t exp;
        pixel_t dir;
        got    = sample(0);
        sinceA = sinceA + 1;
        if (rstA_n == 1'b0) begin
            gapValidA = 1'b0;
        end else if (pixTickA === 1'b1) begin
            if (gapValidA) checkOutput("tickGapA", sinceA, 2);
            gapValidA = 1'b1;
            sinceA    = 0;
            if (qA.size() > 0) begin
                exp = qA.pop_front();
                comparePixel("pixelA", got, exp);
                if (directedPixel(exp.pix, dir)) comparePixel("directedA", got, dir);
            end
            lastA     = got;
            lastA.upd = 1'b0;
        end else if (gapValidA) begin
            comparePixel("holdA", got, lastA);
        end
    end

    // Monitor B: one pixel per clck, so every cycle carries a tick.
    always @(negedge clk) begin
        pixel_t got;
        pixel_t exp;
        pixel_t dir;
        got    = sample(1);
        sinceB = sinceB + 1;
        if (rstB_n == 1'b0) begin
            gapValidB = 1'b0;
        end else if (pixTickB === 1'b1) begin
            if (gapValidB) checkOutput("tickGapB", sinceB, 1);
            gapValidB = 1'b1;
            sinceB    = 0;
            if (qB.size() > 0) begin
                exp = qB.pop_front();
                comparePixel("pixelB", got, exp);
                if (directedPixel(exp.pix, dir)) comparePixel("directedB", got, dir);
            end
        end
    end

    initial begin
        applyStimulus(0, 2 * FRAME + 50);
        applyStimulus(1, FRAME + 10);
        repeat (5) @(posedge clk);
        @(negedge clk);
        checkReset(0);
        checkReset(1);

        @(posedge clk);
        #2;
        rstA_n = 1'b1;
        rstB_n = 1'b1;
        fork
            waitFirstTick(0, 2);
            waitFirstTick(1, 1);
        join
        drain(1, 1000);
        drain(0, 2000);

        // One-cycle reset in the middle of a frame (line 3, column 5).
        #2;
        rstA_n = 1'b0;
        @(posedge clk);
        #2;
        applyStimulus(0, FRAME + 10);
        rstA_n = 1'b1;
        @(negedge clk);
        checkReset(0);
        waitFirstTick(0, 2);
        drain(0, 1000);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #100000;
        $display("[TB] FAIL watchdog: run exceeded time limit, checks=%0d errors=%0d", checks, errors);
        $fatal(1, "[TB] watchdog expired");
    end

endmodule
